// File: rtl/game_pkg.sv
// Shared game definitions: timer state encoding, display widths and the
// binary-to-BCD conversion used by the countdown and score display paths.
package game_pkg;

    localparam int unsigned TIME_W = 7;
    localparam int unsigned BCD_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_e;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd_t;

    // Valid for 0..99, where the tens digit always fits in one BCD nibble.
    function automatic bcd_t bin_to_bcd(input logic [TIME_W-1:0] bin);
        bcd_t r;
        r.tens = BCD_W'(bin / TIME_W'(10));
        r.ones = BCD_W'(bin % TIME_W'(10));
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clkIn down to a one-cycle tick every CLK_DIV enabled cycles;
// the count is held while enable is low so partial periods are kept.
module tick_prescaler #(
    parameter int unsigned CLK_DIV = 100_000_000
) (
    input  logic clkIn,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && (count == TERMINAL);

    always_ff @(posedge clkIn) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_countdown_timer.sv
// Per-game countdown: second prescaler, start/pause/expire control and
// binary plus BCD seconds-remaining for the seven-segment display.
module game_countdown_timer
    import game_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 100_000_000,
    parameter int unsigned GAME_SECONDS = 30,
    parameter int unsigned WARN_SECONDS = 5
) (
    input  logic              clkIn,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    output logic              timer_expired,
    output logic              running,
    output logic              sec_tick,
    output logic              low_time,
    output logic [TIME_W-1:0] time_left,
    output logic [BCD_W-1:0]  bcd_tens,
    output logic [BCD_W-1:0]  bcd_ones
);

    if (GAME_SECONDS < 1 || GAME_SECONDS > 99 || CLK_DIV < 2) begin : g_param_check
        $error("game_countdown_timer: GAME_SECONDS must be 1..99 and CLK_DIV >= 2");
    end

    localparam logic [TIME_W-1:0] GAME_TIME = TIME_W'(GAME_SECONDS);
    localparam logic [TIME_W-1:0] WARN_TIME = TIME_W'(WARN_SECONDS);

    timer_state_e      state_q, state_d;
    logic [TIME_W-1:0] time_d;
    logic              sec_tick_d;
    logic              expired_d;
    logic              running_d;
    logic              presc_en;
    logic              tick;
    bcd_t              bcd_d;
    bcd_t              game_bcd;

    // Start outranks pause, which outranks the tick; PAUSE with pause low
    // resumes counting on the same edge it returns to RUN.
    assign presc_en = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && !pause && !start;

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clkIn  (clkIn),
        .reset  (reset),
        .clear  (start),
        .enable (presc_en),
        .tick   (tick)
    );

    // Next-state, next-count and pulse generation.
    always_comb begin
        state_d    = state_q;
        time_d     = time_left;
        sec_tick_d = 1'b0;
        expired_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                time_d = GAME_TIME;
                if (start) state_d = ST_RUN;
            end
            ST_RUN, ST_PAUSE: begin
                if (start) begin
                    state_d = ST_RUN;
                    time_d  = GAME_TIME;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                    if (tick) begin
                        sec_tick_d = 1'b1;
                        time_d     = time_left - TIME_W'(1);
                        if (time_left == TIME_W'(1)) begin
                            expired_d = 1'b1;
                            state_d   = ST_EXPIRED;
                        end
                    end
                end
            end
            ST_EXPIRED: begin
                time_d = '0;
                if (start) begin
                    state_d = ST_RUN;
                    time_d  = GAME_TIME;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign running_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    assign bcd_d     = bin_to_bcd(time_d);
    assign game_bcd  = bin_to_bcd(GAME_TIME);

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            time_left     <= GAME_TIME;
            bcd_tens      <= game_bcd.tens;
            bcd_ones      <= game_bcd.ones;
            sec_tick      <= 1'b0;
            timer_expired <= 1'b0;
            running       <= 1'b0;
        end else begin
            state_q       <= state_d;
            time_left     <= time_d;
            bcd_tens      <= bcd_d.tens;
            bcd_ones      <= bcd_d.ones;
            sec_tick      <= sec_tick_d;
            timer_expired <= expired_d;
            running       <= running_d;
        end
    end

    assign low_time = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && (time_left <= WARN_TIME);

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer with a per-cycle expected-value
// queue, plus a second instance built with a 30-second game for BCD digits.
module tb_game_countdown_timer;

    localparam int CLK_DIV = 4;
    localparam int GS      = 5;
    localparam int WS      = 2;

    logic       clk = 1'b0;
    logic       reset, start, pause;
    logic       timer_expired, running, sec_tick, low_time;
    logic [6:0] time_left;
    logic [3:0] bcd_tens, bcd_ones;

    logic       r30, s30;
    logic       exp30, run30, tick30, low30;
    logic [6:0] time30;
    logic [3:0] tens30, ones30;

    int total = 0;
    int bad   = 0;
    int n_ticks = 0;
    int n_exp   = 0;

    int m_state, m_cnt, m_time;

    typedef struct {
        int time_left;
        int tens;
        int ones;
        int tick;
        int expd;
        int run;
        int low;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    game_countdown_timer #(.CLK_DIV(CLK_DIV), .GAME_SECONDS(GS), .WARN_SECONDS(WS)) dut (
        .clkIn(clk), .reset(reset), .start(start), .pause(pause),
        .timer_expired(timer_expired), .running(running), .sec_tick(sec_tick),
        .low_time(low_time), .time_left(time_left), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
    );

    game_countdown_timer #(.CLK_DIV(CLK_DIV), .GAME_SECONDS(30), .WARN_SECONDS(5)) dut30 (
        .clkIn(clk), .reset(r30), .start(s30), .pause(1'b0),
        .timer_expired(exp30), .running(run30), .sec_tick(tick30),
        .low_time(low30), .time_left(time30), .bcd_tens(tens30), .bcd_ones(ones30)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        total++;
        assert (obs === 32'(expv)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference behaviour of the timer: 0=IDLE 1=RUN 2=PAUSE 3=EXPIRED.
    task automatic model_step(input bit st, input bit pa, input bit rs, output exp_t e);
        e.tick = 0;
        e.expd = 0;
        if (rs) begin
            m_state = 0; m_cnt = 0; m_time = GS;
        end else if (st) begin
            m_state = 1; m_cnt = 0; m_time = GS;
        end else if (m_state == 1 || m_state == 2) begin
            if (pa) begin
                m_state = 2;
            end else begin
                m_state = 1;
                if (m_cnt == CLK_DIV - 1) begin
                    m_cnt = 0;
                    m_time--;
                    e.tick = 1;
                    if (m_time == 0) begin
                        e.expd = 1;
                        m_state = 3;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
        e.time_left = m_time;
        e.tens      = m_time / 10;
        e.ones      = m_time % 10;
        e.run       = (m_state == 1 || m_state == 2) ? 1 : 0;
        e.low       = (e.run == 1 && m_time <= WS) ? 1 : 0;
    endtask

    task automatic cycle(input bit st, input bit pa, input bit rs);
        exp_t e;
        start = st;
        pause = pa;
        reset = rs;
        model_step(st, pa, rs, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("time_left", time_left, e.time_left);
        chk("bcd_tens", bcd_tens, e.tens);
        chk("bcd_ones", bcd_ones, e.ones);
        chk("sec_tick", sec_tick, e.tick);
        chk("timer_expired", timer_expired, e.expd);
        chk("running", running, e.run);
        chk("low_time", low_time, e.low);
        if (sec_tick === 1'b1) n_ticks++;
        if (timer_expired === 1'b1) n_exp++;
    endtask

    initial begin
        int t0, e0;
        start = 1'b0; pause = 1'b0; reset = 1'b1;
        r30 = 1'b1; s30 = 1'b0;

        // Reset state
        repeat (2) cycle(0, 0, 1);
        cycle(0, 0, 0);
        chk("rst_time", time_left, 5);
        chk("rst_running", running, 0);

        // 1: single-cycle start, full countdown
        e0 = n_exp;
        cycle(1, 0, 0);
        chk("t1_time0", time_left, 5);
        for (int i = 1; i <= 20; i++) begin
            cycle(0, 0, 0);
            chk("t1_tick", sec_tick, (i % 4 == 0) ? 1 : 0);
            chk("t1_time", time_left, 5 - i / 4);
        end
        chk("t1_expired", timer_expired, 1);
        cycle(0, 0, 0);
        chk("t1_expired_once", n_exp - e0, 1);
        chk("t1_running", running, 0);
        chk("t1_bcd", {bcd_tens, bcd_ones}, 0);

        // 2: pause with two prescaler counts into second 3
        cycle(1, 0, 0);
        repeat (8) cycle(0, 0, 0);
        chk("t2_time3", time_left, 3);
        repeat (2) cycle(0, 0, 0);
        t0 = n_ticks;
        repeat (10) cycle(0, 1, 0);
        chk("t2_pause_ticks", n_ticks - t0, 0);
        chk("t2_pause_time", time_left, 3);
        chk("t2_pause_running", running, 1);
        cycle(0, 0, 0);
        chk("t2_rel1_tick", sec_tick, 0);
        cycle(0, 0, 0);
        chk("t2_rel2_tick", sec_tick, 1);
        chk("t2_time2", time_left, 2);
        chk("t2_low", low_time, 1);
        repeat (8) cycle(0, 0, 0);
        chk("t2_expired", timer_expired, 1);

        // 3: start on terminal count with one second left
        e0 = n_exp;
        cycle(1, 0, 0);
        repeat (19) cycle(0, 0, 0);
        chk("t3_time1", time_left, 1);
        cycle(1, 0, 0);
        chk("t3_no_expire", timer_expired, 0);
        chk("t3_no_tick", sec_tick, 0);
        chk("t3_reload", time_left, 5);
        chk("t3_running", running, 1);
        repeat (4) cycle(0, 0, 0);
        chk("t3_continue", time_left, 4);
        repeat (16) cycle(0, 0, 0);
        chk("t3_one_expire", n_exp - e0, 1);

        // 4: restart from EXPIRED
        repeat (5) cycle(0, 0, 0);
        chk("t4_hold0", time_left, 0);
        e0 = n_exp;
        cycle(1, 0, 0);
        chk("t4_reload", time_left, 5);
        repeat (20) cycle(0, 0, 0);
        chk("t4_expired", timer_expired, 1);
        repeat (5) cycle(0, 0, 0);
        chk("t4_one_expire", n_exp - e0, 1);

        // 5: reset mid-second at 3, and reset on the expiry edge
        cycle(1, 0, 0);
        repeat (9) cycle(0, 0, 0);
        chk("t5_time3", time_left, 3);
        cycle(0, 0, 1);
        chk("t5_time", time_left, 5);
        chk("t5_running", running, 0);
        chk("t5_tick", sec_tick, 0);
        t0 = n_ticks;
        repeat (10) cycle(0, 0, 0);
        chk("t5_idle_ticks", n_ticks - t0, 0);
        chk("t5_idle_time", time_left, 5);
        cycle(1, 0, 0);
        repeat (19) cycle(0, 0, 0);
        cycle(0, 0, 1);
        chk("t5_pending_expire", timer_expired, 0);
        chk("t5_pending_time", time_left, 5);
        cycle(0, 0, 0);

        // 6: 30-second build BCD digits
        r30 = 1'b0; s30 = 1'b1;
        cycle(0, 0, 0);
        s30 = 1'b0;
        chk("t6_tens_start", tens30, 3);
        chk("t6_ones_start", ones30, 0);
        repeat (4) cycle(0, 0, 0);
        chk("t6_tens_29", tens30, 2);
        chk("t6_ones_29", ones30, 9);
        repeat (80) cycle(0, 0, 0);
        chk("t6_time9", time30, 9);
        chk("t6_tens_9", tens30, 0);
        chk("t6_ones_9", ones30, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
